integral_image_builder: RTL and testbench

//  Builds the WIN_W x WIN_H integral image of one grayscale detection window from a

---
 rtl/integral_image_builder.sv | 111 +++++++++++
 tb/tb_integral_image_builder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/integral_image_builder.sv
// Streams one WIN_W x WIN_H window in raster order and builds its integral image.
// The finished image is published with a START level held until result_taken.
module integral_image_builder #(
    parameter int unsigned WIN_W = 20,
    parameter int unsigned WIN_H = 20,
    parameter int unsigned PIX_W = 8,
    parameter int unsigned SUM_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             pixel_valid,
    input  logic             pixel_sof,
    output logic             pixel_ready,
    input  logic             result_taken,
    output logic [SUM_W-1:0] integral_buffer [WIN_W*WIN_H],
    output logic             START
);

    localparam int unsigned N  = WIN_W * WIN_H;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned XW = $clog2(WIN_W + 1);
    localparam int unsigned YW = $clog2(WIN_H + 1);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e           state_q;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [IW-1:0]    idx_q;
    logic [SUM_W-1:0] row_sum_q;
    logic             start_q;
    logic [SUM_W-1:0] buf_q [N];

    logic             beat, restart, wr_en, wr_last_col, wr_last_row;
    logic [XW-1:0]    wr_x;
    logic [YW-1:0]    wr_y;
    logic [IW-1:0]    wr_idx, up_idx;
    logic [SUM_W-1:0] row_sum_d, above, wr_val;

    assign pixel_ready     = ~Reset & (state_q != StHold);
    assign START           = start_q;
    assign integral_buffer = buf_q;

    always_comb begin
        beat        = pixel_valid & pixel_ready;
        restart     = beat & pixel_sof;
        // In IDLE only a start-of-frame beat writes; other beats are dropped.
        wr_en       = beat & (pixel_sof | (state_q == StAccum));
        wr_x        = restart ? '0 : x_q;
        wr_y        = restart ? '0 : y_q;
        wr_idx      = restart ? '0 : idx_q;
        wr_last_col = (wr_x == XW'(WIN_W - 1));
        wr_last_row = (wr_y == YW'(WIN_H - 1));
        row_sum_d   = ((wr_x == '0) ? '0 : row_sum_q) + SUM_W'(pixel_in);
        up_idx      = (wr_y == '0) ? '0 : wr_idx - IW'(WIN_W);
        above       = (wr_y == '0) ? '0 : buf_q[up_idx];
        wr_val      = row_sum_d + above;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            idx_q     <= '0;
            row_sum_q <= '0;
            start_q   <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle, StAccum: begin
                    if (wr_en) begin
                        buf_q[wr_idx] <= wr_val;
                        row_sum_q     <= row_sum_d;
                        if (wr_last_col && wr_last_row) begin
                            state_q <= StHold;
                            start_q <= 1'b1;
                            x_q     <= '0;
                            y_q     <= '0;
                            idx_q   <= '0;
                        end else if (wr_last_col) begin
                            state_q <= StAccum;
                            x_q     <= '0;
                            y_q     <= wr_y + 1'b1;
                            idx_q   <= wr_idx + 1'b1;
                        end else begin
                            state_q <= StAccum;
                            x_q     <= wr_x + 1'b1;
                            y_q     <= wr_y;
                            idx_q   <= wr_idx + 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (result_taken) begin
                        state_q <= StIdle;
                        start_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_integral_image_builder.sv
// Bench for integral_image_builder: random and patterned frames checked against an
// integral image computed by inclusion-exclusion from the pixel array.
module tb_integral_image_builder;

    localparam int W = 20;
    localparam int H = 20;
    localparam int N = W * H;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  pixel_in;
    logic        pixel_valid;
    logic        pixel_sof;
    logic        pixel_ready;
    logic        result_taken;
    logic [31:0] ib [N];
    logic        START;

    integral_image_builder #(
        .WIN_W(W), .WIN_H(H), .PIX_W(8), .SUM_W(32)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .pixel_in       (pixel_in),
        .pixel_valid    (pixel_valid),
        .pixel_sof      (pixel_sof),
        .pixel_ready    (pixel_ready),
        .result_taken   (result_taken),
        .integral_buffer(ib),
        .START          (START)
    );

    always #5 Clk = ~Clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned pix    [N];
    int unsigned exp_ii [N];
    int          early_start;
    int          ready_drop;

    function automatic void build_model();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int unsigned v;
                v = pix[y*W+x];
                if (x > 0) v += exp_ii[y*W+x-1];
                if (y > 0) v += exp_ii[(y-1)*W+x];
                if (x > 0 && y > 0) v -= exp_ii[(y-1)*W+x-1];
                exp_ii[y*W+x] = v;
            end
        end
    endfunction

    function automatic int count_diff();
        int c = 0;
        for (int i = 0; i < N; i++) if (ib[i] !== exp_ii[i]) c++;
        return c;
    endfunction

    function automatic int count_nonzero();
        int c = 0;
        for (int i = 0; i < N; i++) if (ib[i] !== 32'd0) c++;
        return c;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_stream(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                pixel_valid = 1'b0;
                pixel_sof   = 1'b0;
                pixel_in    = 8'($urandom);
                if (START !== 1'b0) early_start++;
                if (pixel_ready !== 1'b1) ready_drop++;
                tick();
            end
            pixel_in    = 8'(pix[i]);
            pixel_valid = 1'b1;
            pixel_sof   = (i == 0);
            if (START !== 1'b0) early_start++;
            if (pixel_ready !== 1'b1) ready_drop++;
            tick();
        end
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
    endtask

    task automatic release_hold(input string tag);
        result_taken = 1'b1;
        tick();
        result_taken = 1'b0;
        n_tests++;
        if (START !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release_start: got %b want 0", tag, START);
        end
        n_tests++;
        if (pixel_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_release_ready: got %b want 1", tag, pixel_ready);
        end
    endtask

    task automatic check_frame(input string tag);
        int d;
        n_tests++;
        if (early_start != 0 || ready_drop != 0) begin
            n_fail++;
            $display("FAIL %s_stream: early START cycles %0d, ready low cycles %0d, want 0/0",
                     tag, early_start, ready_drop);
        end
        n_tests++;
        if (START !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_start_latency: got %b want 1", tag, START);
        end
        d = count_diff();
        n_tests++;
        if (d != 0) begin
            n_fail++;
            $display("FAIL %s_buffer: %0d entries differ, ib[399]=%0d want %0d",
                     tag, d, ib[N-1], exp_ii[N-1]);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; pixel_valid = 1'b0; pixel_sof = 1'b0; pixel_in = '0;
        result_taken = 1'b0;
        tick();
        tick();
        n_tests++;
        if (START !== 1'b0 || pixel_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: START=%b ready=%b want 0/0", START, pixel_ready);
        end
        n_tests++;
        if (count_nonzero() != 0) begin
            n_fail++;
            $display("FAIL reset_buffer: %0d nonzero entries want 0", count_nonzero());
        end
        Reset = 1'b0;
        tick();
        n_tests++;
        if (pixel_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: got %b want 1", pixel_ready);
        end
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < N; i++) pix[i] = 1;
        build_model();
        early_start = 0; ready_drop = 0;
        drive_stream(N, 0);
        check_frame("ones");
        n_tests++;
        if (ib[N-1] !== 32'd400 || ib[21] !== 32'd4) begin
            n_fail++;
            $display("FAIL ones_corner: ib[399]=%0d ib[21]=%0d want 400/4", ib[N-1], ib[21]);
        end
        release_hold("ones");
    endtask

    task automatic test_all_255_gaps();
        for (int i = 0; i < N; i++) pix[i] = 255;
        build_model();
        early_start = 0; ready_drop = 0;
        drive_stream(N, 30);
        check_frame("max");
        n_tests++;
        if (ib[N-1] !== 32'd102000 || ib[19] !== 32'd5100 || ib[380] !== 32'd5100) begin
            n_fail++;
            $display("FAIL max_corners: ib[399]=%0d ib[19]=%0d ib[380]=%0d want 102000/5100/5100",
                     ib[N-1], ib[19], ib[380]);
        end
        release_hold("max");
    endtask

    task automatic test_hold();
        int rdy_hi = 0;
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) pix[y*W+x] = x + y;
        build_model();
        early_start = 0; ready_drop = 0;
        drive_stream(N, 0);
        check_frame("ramp");
        n_tests++;
        if (ib[21] !== 32'd4 || ib[N-1] !== 32'd7600) begin
            n_fail++;
            $display("FAIL ramp_entries: ib[21]=%0d ib[399]=%0d want 4/7600", ib[21], ib[N-1]);
        end
        for (int k = 0; k < 6; k++) begin
            pixel_valid = 1'b1;
            pixel_sof   = 1'($urandom_range(1));
            pixel_in    = 8'($urandom_range(1, 255));
            if (pixel_ready !== 1'b0) rdy_hi++;
            tick();
        end
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
        n_tests++;
        if (rdy_hi != 0) begin
            n_fail++;
            $display("FAIL hold_ready: ready high %0d cycles want 0", rdy_hi);
        end
        n_tests++;
        if (count_diff() != 0 || START !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_frozen: %0d entries changed, START=%b want 0/1",
                     count_diff(), START);
        end
        release_hold("hold");
    endtask

    task automatic test_idle_drop();
        for (int k = 0; k < 12; k++) begin
            pixel_valid = 1'b1;
            pixel_sof   = 1'b0;
            pixel_in    = 8'($urandom_range(1, 255));
            tick();
        end
        pixel_valid = 1'b0;
        n_tests++;
        if (count_diff() != 0 || START !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_drop: %0d entries written, START=%b want 0/0",
                     count_diff(), START);
        end
        for (int i = 0; i < N; i++) pix[i] = 1;
        build_model();
        early_start = 0; ready_drop = 0;
        drive_stream(N, 15);
        check_frame("after_drop");
        release_hold("after_drop");
    endtask

    task automatic test_sof_restart();
        for (int i = 0; i < N; i++) pix[i] = $urandom_range(255);
        early_start = 0; ready_drop = 0;
        drive_stream(150, 10);
        for (int i = 0; i < N; i++) pix[i] = 1;
        build_model();
        drive_stream(N, 0);
        check_frame("restart");
        release_hold("restart");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N; i++) pix[i] = $urandom_range(255);
        drive_stream(200, 0);
        Reset = 1'b1;
        #1;
        n_tests++;
        if (START !== 1'b0 || pixel_ready !== 1'b0 || count_nonzero() != 0) begin
            n_fail++;
            $display("FAIL reset_midframe: START=%b ready=%b nonzero=%0d want 0/0/0",
                     START, pixel_ready, count_nonzero());
        end
        tick();
        Reset = 1'b0;
        tick();
        for (int i = 0; i < N; i++) pix[i] = $urandom_range(255);
        build_model();
        early_start = 0; ready_drop = 0;
        drive_stream(N, 20);
        check_frame("post_reset");
        tick();
        tick();
        Reset = 1'b1;
        #1;
        n_tests++;
        if (START !== 1'b0 || count_nonzero() != 0) begin
            n_fail++;
            $display("FAIL reset_midhold: START=%b nonzero=%0d want 0/0", START, count_nonzero());
        end
        tick();
        Reset = 1'b0;
        tick();
        for (int i = 0; i < N; i++) pix[i] = $urandom_range(255);
        build_model();
        early_start = 0; ready_drop = 0;
        drive_stream(N, 0);
        check_frame("post_hold_reset");
        release_hold("post_hold_reset");
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_all_255_gaps();
        test_hold();
        test_idle_drop();
        test_sof_restart();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
